// File: rtl/riscv_lsu.sv
// Load/store unit: turns decoder memory controls into a request/ready data-memory
// access, stalls the core until completion and formats load data for write-back.
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_legal(input logic we, input logic [2:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            LDST_B:  ok = 1'b1;
            LDST_BU: ok = ~we;
            LDST_H:  ok = ~lo[0];
            LDST_HU: ok = ~we & ~lo[0];
            LDST_W:  ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            LDST_B, LDST_BU: be = 4'b0001 << lo;
            LDST_H, LDST_HU: be = 4'b0011 << lo;
            default:         be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wd(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] r;
        case (size)
            LDST_B, LDST_BU: r = {4{wd[7:0]}};
            LDST_H, LDST_HU: r = {2{wd[15:0]}};
            default:         r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] fmt_rd(input logic [2:0] size, input logic [1:0] lo,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{lo, 3'b000} +: 8];
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (size)
            LDST_B:  r = {{24{b[7]}}, b};
            LDST_BU: r = {24'd0, b};
            LDST_H:  r = {{16{h[15]}}, h};
            LDST_HU: r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        to_err_q, to_err_d;
    logic        stall_s;
    logic        err_s;
    logic        legal_s;
    logic [CW-1:0] cnt_inc_s;

    // Next-state, datapath capture and combinational core handshake.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        size_d    = size_q;
        lo_d      = lo_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        to_err_d  = 1'b0;
        stall_s   = 1'b0;
        err_s     = 1'b0;
        legal_s   = is_legal(core_we_i, core_size_i, core_addr_i[1:0]);
        cnt_inc_s = cnt_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                if (core_req_i && legal_s) begin
                    stall_s = 1'b1;
                    addr_d  = {core_addr_i[31:2], 2'b00};
                    we_d    = core_we_i;
                    be_d    = byte_en(core_size_i, core_addr_i[1:0]);
                    wd_d    = lane_wd(core_size_i, core_wd_i);
                    size_d  = core_size_i;
                    lo_d    = core_addr_i[1:0];
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end else if (core_req_i) begin
                    err_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                if (mem_ready_i) begin
                    if (!we_q) begin
                        rd_d = fmt_rd(size_q, lo_q, mem_rd_i);
                    end else begin
                        rd_d = rd_q;
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_inc_s == TO_LIMIT)) begin
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    cnt_d    = '0;
                    to_err_d = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_RESP: begin
                // The timeout error is reported while the core retires the access.
                err_s   = to_err_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            addr_q   <= 32'd0;
            wd_q     <= 32'd0;
            size_q   <= 3'd0;
            lo_q     <= 2'd0;
            rd_q     <= 32'd0;
            cnt_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            size_q   <= size_d;
            lo_q     <= lo_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign core_rd_o    = rd_q;
    assign core_stall_o = stall_s;
    assign core_err_o   = err_s;
    assign mem_req_o    = req_q;
    assign mem_we_o     = we_q;
    assign mem_be_o     = be_q;
    assign mem_addr_o   = addr_q;
    assign mem_wd_o     = wd_q;

endmodule
